// File: rtl/gcd_unit_param.sv
// ---------------------------------------------------------------------------
// gcd_unit_param
//
// Greatest common divisor of two unsigned WIDTH-bit operands, computed with
// an iterative Euclidean subtract/swap loop (one step per clock).
// Each response carries the request's tag and a saturating count of the
// subtract/swap steps taken. A new request can be accepted on the same edge
// that consumes the previous response, so there is no idle cycle in between.
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous, active-high reset
//   req_msg      operands {a, b}: a = [2*WIDTH-1:WIDTH], b = [WIDTH-1:0]
//   req_tag      tag captured with the request
//   req_val      request valid
//   req_rdy      request ready (combinational from resp_rdy, 0 during reset)
//   resp_msg     gcd(a, b)
//   resp_tag     tag of the request being answered
//   resp_cycles  number of compute steps, saturating at 2^CNT_W-1
//   resp_val     response valid
//   resp_rdy     response ready
// ---------------------------------------------------------------------------
module gcd_unit_param #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2*WIDTH-1:0] req_msg,
    input  logic [TAG_W-1:0]   req_tag,
    input  logic               req_val,
    output logic               req_rdy,
    output logic [WIDTH-1:0]   resp_msg,
    output logic [TAG_W-1:0]   resp_tag,
    output logic [CNT_W-1:0]   resp_cycles,
    output logic               resp_val,
    input  logic               resp_rdy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [TAG_W-1:0]   tag_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               resp_val_reg;

    logic               accept;
    logic               cnt_full;
    logic [CNT_W-1:0]   cnt_next;

    // Ready while idle, or while finishing if the current response is being
    // taken this cycle; held low during reset so nothing is accepted then.
    assign req_rdy  = !reset &&
                      ((state_reg == IDLE) || ((state_reg == DONE) && resp_rdy));
    assign accept   = req_val && req_rdy;

    // Saturating step counter: stop at all-ones instead of wrapping.
    assign cnt_full = &cnt_reg;
    assign cnt_next = cnt_full ? cnt_reg : cnt_reg + CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            a_reg        <= '0;
            b_reg        <= '0;
            tag_reg      <= '0;
            cnt_reg      <= '0;
            resp_val_reg <= 1'b0;
        end else if (accept) begin
            // Covers both a load from IDLE and a back-to-back load on the
            // edge that consumes the previous response.
            a_reg        <= req_msg[2*WIDTH-1:WIDTH];
            b_reg        <= req_msg[WIDTH-1:0];
            tag_reg      <= req_tag;
            cnt_reg      <= '0;
            resp_val_reg <= 1'b0;
            state_reg    <= CALC;
        end else begin
            case (state_reg)
                CALC: begin
                    if (a_reg < b_reg) begin
                        a_reg   <= b_reg;
                        b_reg   <= a_reg;
                        cnt_reg <= cnt_next;
                    end else if (b_reg != '0) begin
                        a_reg   <= a_reg - b_reg;
                        cnt_reg <= cnt_next;
                    end else begin
                        // Termination step is not counted.
                        state_reg    <= DONE;
                        resp_val_reg <= 1'b1;
                    end
                end
                DONE: begin
                    // Result registers stay untouched so the response is
                    // stable until the consumer takes it.
                    if (resp_rdy) begin
                        state_reg    <= IDLE;
                        resp_val_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    resp_val_reg <= 1'b0;
                end
            endcase
        end
    end

    assign resp_val    = resp_val_reg;
    assign resp_msg    = a_reg;
    assign resp_tag    = tag_reg;
    assign resp_cycles = cnt_reg;

endmodule

// File: tb/tb_gcd_unit_param.sv
// ---------------------------------------------------------------------------
// tb_gcd_unit_param
//
// Scoreboard bench for gcd_unit_param (WIDTH=8, TAG_W=4, CNT_W=5 so that
// counter saturation is reachable quickly). The driver pushes the expected
// response when a request is accepted; a monitor compares every presented
// response against the queue head, checks latency on the rising edge of
// resp_val and pops on consume.
// ---------------------------------------------------------------------------
module tb_gcd_unit_param;

    localparam int W = 8;
    localparam int T = 4;
    localparam int C = 5;
    localparam int CNT_MAX = (1 << C) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [2*W-1:0]   req_msg = '0;
    logic [T-1:0]     req_tag = '0;
    logic             req_val = 1'b0;
    logic             req_rdy;
    logic [W-1:0]     resp_msg;
    logic [T-1:0]     resp_tag;
    logic [C-1:0]     resp_cycles;
    logic             resp_val;
    logic             resp_rdy = 1'b1;

    gcd_unit_param #(.WIDTH(W), .TAG_W(T), .CNT_W(C)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_msg     (req_msg),
        .req_tag     (req_tag),
        .req_val     (req_val),
        .req_rdy     (req_rdy),
        .resp_msg    (resp_msg),
        .resp_tag    (resp_tag),
        .resp_cycles (resp_cycles),
        .resp_val    (resp_val),
        .resp_rdy    (resp_rdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] msg;
        logic [T-1:0] tag;
        int           cyc;
        int           lat;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc_cnt = 0;
    bit   rand_mode = 1'b0;
    bit   rdy_force = 1'b1;
    bit   prev_val = 1'b0;

    always @(posedge clk) cyc_cnt++;

    // Response-ready generator: applied 2 time units after each edge.
    always begin
        @(posedge clk);
        #2;
        resp_rdy = rand_mode ? ($urandom_range(0, 3) != 0) : rdy_force;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: Euclid by division. Each division step with quotient q
    // costs q subtractions plus one swap in the subtract/swap formulation.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] g, output int n);
        int x, y, t;
        x = int'(a);
        y = int'(b);
        n = 0;
        while (y != 0) begin
            n += x / y + 1;
            t = x % y;
            x = y;
            y = t;
        end
        g = W'(x);
    endfunction

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [T-1:0] tag);
        exp_t e;
        int   n;
        req_msg = {a, b};
        req_tag = tag;
        req_val = 1'b1;
        for (int i = 0; ; i++) begin
            @(negedge clk);
            if (req_rdy) begin
                model(a, b, e.msg, n);
                e.tag = tag;
                e.cyc = (n > CNT_MAX) ? CNT_MAX : n;
                e.lat = n + 1;
                e.acc = cyc_cnt + 1;
                sb.push_back(e);
                $display("[TB] req a=%0d b=%0d tag=%0d exp gcd=%0d cycles=%0d", a, b, tag, e.msg, e.cyc);
                break;
            end
            if (i > 3000) begin
                check("req_accept_timeout", 32'(req_rdy), 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        req_val = 1'b0;
        req_msg = 2*W'($urandom);   // must have no effect outside an accept
        req_tag = T'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 5000 && sb.size() != 0; i++) @(posedge clk);
        check("drain_queue_empty", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares whatever the DUT presents with the scoreboard head.
    always @(negedge clk) begin
        if (!reset && resp_val) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", 32'(resp_val), 32'd0);
            end else begin
                if (!prev_val) check("latency", 32'(cyc_cnt), 32'(sb[0].acc + sb[0].lat));
                check("resp_msg", 32'(resp_msg), 32'(sb[0].msg));
                check("resp_tag", 32'(resp_tag), 32'(sb[0].tag));
                check("resp_cycles", 32'(resp_cycles), 32'(sb[0].cyc));
                check("req_rdy_in_done", 32'(req_rdy), 32'(resp_rdy));
                if (resp_rdy) begin
                    $display("[TB] resp msg=%0d tag=%0d cycles=%0d", resp_msg, resp_tag, resp_cycles);
                    void'(sb.pop_front());
                end
            end
        end
        prev_val = resp_val;
    end

    initial begin
        // Reset state.
        #1;
        check("rst_resp_val", 32'(resp_val), 32'd0);
        check("rst_req_rdy", 32'(req_rdy), 32'd0);
        check("rst_resp_msg", 32'(resp_msg), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("req_rdy_after_reset", 32'(req_rdy), 32'd1);
        @(posedge clk);
        #1;

        // Basic case and zero operands back to back.
        send(8'd15, 8'd5, 4'd3);
        drain();
        send(8'd0, 8'd0, 4'd1);
        send(8'd7, 8'd0, 4'd2);
        send(8'd0, 8'd7, 4'd4);
        drain();

        // Backpressure: response held, then consumed with a same-edge accept.
        rdy_force = 1'b0;
        send(8'd12, 8'd18, 4'd9);
        for (int i = 0; i < 200 && !resp_val; i++) @(posedge clk);
        check("bp_resp_val_seen", 32'(resp_val), 32'd1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("bp_req_rdy_low", 32'(req_rdy), 32'd0);
        @(posedge clk);
        #1;
        rdy_force = 1'b1;
        send(8'd21, 8'd14, 4'd5);
        drain();

        // Counter saturation: 201 true steps against a 5-bit counter.
        send(8'd200, 8'd1, 4'd6);
        drain();

        // Asynchronous reset in the middle of a computation.
        send(8'd200, 8'd3, 4'd7);
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("mid_rst_resp_val", 32'(resp_val), 32'd0);
        check("mid_rst_resp_msg", 32'(resp_msg), 32'd0);
        check("mid_rst_resp_tag", 32'(resp_tag), 32'd0);
        check("mid_rst_resp_cycles", 32'(resp_cycles), 32'd0);
        check("mid_rst_req_rdy", 32'(req_rdy), 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        send(8'd200, 8'd3, 4'd8);
        drain();

        // Random operands with random response backpressure.
        rand_mode = 1'b1;
        for (int i = 0; i < 100; i++) begin
            logic [W-1:0] ra, rb;
            ra = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            send(ra, rb, T'(i));
        end
        drain();
        rand_mode = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
